// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Contents: data width, reset/NOP defaults, fetch FSM state enum, buffered
// entry layout {pc, instr}.
package instr_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic {
        BOOT  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Instruction buffer: power-of-2 deep FIFO of {pc, instr} entries.
// Ports: clk, rst_n; i_push/i_data write, i_pop read (ignored when empty),
// i_flush empties the buffer and wins over push; o_head is the oldest entry
// (undefined when empty), o_count the current fill level.
module instr_fetch_unit_fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  fetch_entry_t       i_data,
    input  logic               i_pop,
    input  logic               i_flush,
    output fetch_entry_t       o_head,
    output logic [CNT_W-1:0]   o_count
);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_pop;

    assign w_pop   = i_pop & (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order req/gnt/rvalid
// fetches, buffers returned words and hands them to IF/ID with valid/stall.
// Ports: clk, rst_n; i_fetch_en gates new requests; o_imem_req/o_imem_addr,
// i_imem_gnt, i_imem_rvalid/i_imem_rdata memory side; i_redirect_valid/
// i_redirect_pc flush and restart; i_stall holds the output; o_if_valid,
// o_if_instr, o_if_pc to IF/ID.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int unsigned     FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] NOP_INSTR  = NOP_INSTR_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_fetch_en,
    output logic             o_imem_req,
    output logic [XLEN-1:0]  o_imem_addr,
    input  logic             i_imem_gnt,
    input  logic             i_imem_rvalid,
    input  logic [XLEN-1:0]  i_imem_rdata,
    input  logic             i_redirect_valid,
    input  logic [XLEN-1:0]  i_redirect_pc,
    input  logic             i_stall,
    output logic             o_if_valid,
    output logic [XLEN-1:0]  o_if_instr,
    output logic [XLEN-1:0]  o_if_pc
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_rsp_pc;
    logic [XLEN-1:0]    r_last_pc;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   r_drop;
    logic [CNT_W-1:0]   w_outstanding_nxt;
    logic [CNT_W-1:0]   w_fifo_count;
    logic [XLEN-1:0]    w_redirect_pc;
    logic               w_credit;
    logic               w_req;
    logic               w_gnt;
    logic               w_rv;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_data;

    // Every in-flight request has a guaranteed FIFO slot, so the buffer never overflows.
    assign w_credit = (SUM_W'(r_outstanding) + SUM_W'(w_fifo_count)) < SUM_W'(FIFO_DEPTH);

    // Fetch FSM next state and request
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            BOOT:    w_state_nxt = FETCH;
            FETCH:   w_req       = i_fetch_en & w_credit;
            default: w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_redirect_pc     = i_redirect_pc & ~XLEN'(3);
    assign w_gnt             = w_req & i_imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rv              = i_imem_rvalid & (r_outstanding != '0);
    assign w_push            = w_rv & (r_drop == '0) & ~i_redirect_valid;
    assign w_valid           = (w_fifo_count != '0);
    assign w_pop             = w_valid & ~i_stall;
    assign w_outstanding_nxt = r_outstanding + CNT_W'(w_gnt) - CNT_W'(w_rv);
    assign w_push_data       = '{pc: r_rsp_pc, instr: i_imem_rdata};

    instr_fetch_unit_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (i_redirect_valid),
        .o_head  (w_head),
        .o_count (w_fifo_count)
    );

    // PC, credit and drop bookkeeping. Responses are in order and sequential,
    // so the PC of the next kept response is tracked by r_rsp_pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_last_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (w_pop) begin
                r_last_pc <= w_head.pc;
            end
            if (i_redirect_valid) begin
                // Everything still owed by memory, incl. this cycle's grant, is stale.
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_drop     <= w_outstanding_nxt;
            end else begin
                if (w_gnt) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + XLEN'(4);
                end
                if (w_rv && (r_drop != '0)) begin
                    r_drop <= r_drop - CNT_W'(1);
                end
            end
        end
    end

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_fetch_pc;
    assign o_if_valid  = w_valid;
    assign o_if_instr  = w_valid ? w_head.instr : NOP_INSTR;
    assign o_if_pc     = w_valid ? w_head.pc    : r_last_pc;

    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) i_imem_rvalid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a reset-release vector table,
// directed multi-cycle sequences and a randomized run against a queue-based
// reference model with an in-order memory responder.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] WORD  = 32'h0050_0093;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_fetch_en       (fetch_en),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_gnt       (imem_gnt),
        .i_imem_rvalid    (imem_rvalid),
        .i_imem_rdata     (imem_rdata),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_stall          (stall),
        .o_if_valid       (if_valid),
        .o_if_instr       (if_instr),
        .o_if_pc          (if_pc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] data_of(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    // Reference model: buffered words, in-flight fetches tagged stale on redirect.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] pc; bit stale; } inf_t;
    typedef struct { logic [31:0] addr; int unsigned ready; } mreq_t;

    ent_t        m_fifo[$];
    inf_t        m_inf[$];
    mreq_t       mem_q[$];
    logic [31:0] m_pc, m_last;
    bit          m_booted;
    int unsigned cyc, lat_lo, lat_hi;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc;

    task automatic model_clear();
        m_fifo.delete(); m_inf.delete(); mem_q.delete();
        m_pc = '0; m_last = '0; m_booted = 0; cyc = 0;
    endtask

    task automatic idle_inputs();
        fetch_en = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        redirect_valid = 0; redirect_pc = '0; stall = 0;
    endtask

    // Called just after a posedge; chk verifies the asynchronous reset values.
    task automatic do_reset(bit chk);
        #2 rst_n = 1'b0;
        idle_inputs();
        model_clear();
        if (chk) begin
            #1;
            check("async_rst_req",   32'(imem_req), 32'd0);
            check("async_rst_addr",  imem_addr,     32'h0);
            check("async_rst_valid", 32'(if_valid), 32'd0);
            check("async_rst_instr", if_instr,      NOP);
            check("async_rst_pc",    if_pc,         32'h0);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One clock: drive, compare against the model, advance memory and model.
    task automatic step(bit fe, bit gn, bit st, bit rd, logic [31:0] rpc);
        bit          rv, e_req, e_valid;
        logic [31:0] rdv, e_instr, e_pc;
        ent_t        e;
        inf_t        f;
        @(negedge clk);
        rv  = (mem_q.size() > 0) && (mem_q[0].ready <= cyc);
        rdv = rv ? data_of(mem_q[0].addr) : $urandom;
        fetch_en = fe; imem_gnt = gn; stall = st; redirect_valid = rd; redirect_pc = rpc;
        imem_rvalid = rv; imem_rdata = rdv;
        #1;
        e_req   = m_booted && fe && ((m_inf.size() + m_fifo.size()) < DEPTH);
        e_valid = (m_fifo.size() > 0);
        e_instr = e_valid ? m_fifo[0].instr : NOP;
        e_pc    = e_valid ? m_fifo[0].pc    : m_last;
        check("imem_req",  32'(imem_req), 32'(e_req));
        check("imem_addr", imem_addr,     m_pc);
        check("if_valid",  32'(if_valid), 32'(e_valid));
        check("if_instr",  if_instr,      e_instr);
        check("if_pc",     if_pc,         e_pc);
        s_req = imem_req; s_addr = imem_addr; s_valid = if_valid; s_instr = if_instr; s_pc = if_pc;
        if (rv) void'(mem_q.pop_front());
        if (e_req && gn) mem_q.push_back('{addr: m_pc, ready: cyc + $urandom_range(lat_hi, lat_lo)});
        if (e_valid && !st) begin
            m_last = m_fifo[0].pc;
            void'(m_fifo.pop_front());
        end
        if (rv && m_inf.size() > 0) begin
            f = m_inf.pop_front();
            if (!f.stale && !rd) begin
                e.pc = f.pc; e.instr = rdv;
                m_fifo.push_back(e);
            end
        end
        if (e_req && gn) begin
            m_inf.push_back('{pc: m_pc, stale: rd});
            m_pc = m_pc + 32'd4;
        end
        if (rd) begin
            m_fifo.delete();
            foreach (m_inf[k]) m_inf[k].stale = 1;
            m_pc = rpc & ~32'h3;
        end
        m_booted = 1;
        cyc++;
        @(posedge clk);
    endtask

    typedef struct {
        bit rv; bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_instr; logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        bit          found_req, found_val;
        logic [31:0] pcs[$];

        // Reset release with 1-cycle memory, gnt always high, constant word
        tbl[0] = '{0, 0, 32'h00, 0, NOP,  32'h0};
        tbl[1] = '{0, 1, 32'h00, 0, NOP,  32'h0};
        tbl[2] = '{1, 1, 32'h04, 0, NOP,  32'h0};
        tbl[3] = '{1, 0, 32'h08, 1, WORD, 32'h0};
        tbl[4] = '{0, 1, 32'h08, 1, WORD, 32'h4};
        tbl[5] = '{1, 1, 32'h0C, 0, NOP,  32'h4};
        tbl[6] = '{1, 0, 32'h10, 1, WORD, 32'h8};
        tbl[7] = '{0, 1, 32'h10, 1, WORD, 32'hC};

        lat_lo = 1; lat_hi = 1;
        do_reset(0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            fetch_en = 1; imem_gnt = 1; stall = 0; redirect_valid = 0;
            imem_rvalid = tbl[i].rv; imem_rdata = WORD;
            #1;
            check($sformatf("tbl%0d_req", i),   32'(imem_req), 32'(tbl[i].e_req));
            check($sformatf("tbl%0d_addr", i),  imem_addr,     tbl[i].e_addr);
            check($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_instr", i), if_instr,      tbl[i].e_instr);
            check($sformatf("tbl%0d_pc", i),    if_pc,         tbl[i].e_pc);
        end
        @(posedge clk);

        // Stall for 5 cycles: credits cap the buffer, request drops
        do_reset(0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, '0);
        check("stall_req_low",  32'(s_req),   32'd0);
        check("stall_valid",    32'(s_valid), 32'd1);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, '0);

        // Redirect to 0x102 with two fetches in flight
        lat_lo = 3; lat_hi = 3;
        do_reset(0);
        step(1, 1, 0, 0, '0);
        step(1, 1, 0, 0, '0);
        step(1, 1, 0, 0, '0);
        step(1, 1, 0, 1, 32'h0000_0102);
        found_req = 0; found_val = 0;
        for (int i = 0; i < 20 && !(found_req && found_val); i++) begin
            step(1, 1, 0, 0, '0);
            if (s_req && !found_req) begin
                found_req = 1;
                check("redir_first_addr", s_addr, 32'h100);
            end
            if (s_valid && !found_val) begin
                found_val = 1;
                check("redir_first_pc", s_pc, 32'h100);
            end
        end
        check("redir_seen_req_and_valid", 32'({found_req, found_val}), 32'd3);

        // Redirect coinciding with rvalid and gnt
        lat_lo = 1; lat_hi = 1;
        do_reset(0);
        step(1, 1, 0, 0, '0);
        step(1, 1, 0, 0, '0);
        step(1, 1, 0, 1, 32'h0000_0200);
        found_val = 0;
        for (int i = 0; i < 12 && !found_val; i++) begin
            step(1, 1, 0, 0, '0);
            if (s_valid) begin
                found_val = 1;
                check("same_cyc_first_pc",    s_pc,    32'h200);
                check("same_cyc_first_instr", s_instr, data_of(32'h200));
            end
        end
        check("same_cyc_seen_valid", 32'(found_val), 32'd1);

        // Grant withheld for 3 cycles: address held, PC advances only on gnt
        do_reset(0);
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, '0);
            check("gnt_wait_req",  32'(s_req), 32'd1);
            check("gnt_wait_addr", s_addr,     32'h0);
        end
        step(1, 1, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        check("gnt_after_addr", s_addr, 32'h4);

        // PC wrap: park at 0xFFFFFFF8 with fetch disabled, then enable
        do_reset(0);
        step(0, 1, 0, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);
        pcs.delete();
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 0, '0);
            if (s_valid) pcs.push_back(s_pc);
        end
        check("wrap_count_ge3", 32'(pcs.size() >= 3), 32'd1);
        if (pcs.size() >= 3) begin
            check("wrap_pc0", pcs[0], 32'hFFFF_FFF8);
            check("wrap_pc1", pcs[1], 32'hFFFF_FFFC);
            check("wrap_pc2", pcs[2], 32'h0000_0000);
        end

        // Randomized traffic, with an asynchronous reset in the middle
        lat_lo = 1; lat_hi = 4;
        do_reset(0);
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset(1);
            step($urandom_range(9, 0) != 0, $urandom_range(9, 0) < 7,
                 $urandom_range(9, 0) < 3, $urandom_range(99, 0) < 4, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
